// File: rtl/cic_interpolator.sv
// cic_interpolator: low-rate sample FIFO feeding a zero-stuff or hold upsampler
// that emits one output slot per high-rate clock enable.
module cic_interpolator #(
    parameter int W    = 5,
    parameter int R    = 5,
    parameter int RW   = 32,
    parameter int HOLD = 0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_ce,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_underflow
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state, state_n;
    logic [W-1:0]  mem [2];
    logic          rd_ptr, wr_ptr;
    logic [1:0]    count;
    logic [RW-1:0] phase;
    logic [W-1:0]  hold_q, head;
    logic          slot, slot0, push, pop;

    assign o_ready = count < 2'd2;
    assign push    = i_valid && o_ready;
    assign slot    = state == RUN && i_ce;
    assign slot0   = slot && phase == '0;
    assign pop     = slot0 && count != 2'd0;
    // An empty FIFO at slot 0 yields a zero sample and clears the hold value
    assign head    = pop ? mem[rd_ptr] : '0;

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = (state == IDLE && count != 2'd0) ? RUN : state;
    end

    always_ff @(posedge i_clk)
        if (push) mem[wr_ptr] <= i_data;

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= !wr_ptr;
            if (pop) rd_ptr <= !rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            phase       <= '0;
            hold_q      <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_valid     <= slot;
            o_underflow <= slot0 && count == 2'd0;
            if (slot) begin
                phase  <= (phase == RW'(R - 1)) ? '0 : phase + RW'(1);
                o_data <= slot0 ? head : (HOLD != 0 ? hold_q : '0);
                if (slot0) hold_q <= head;
            end
        end
endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: two configurations (R=5 zero-stuff, R=4 hold) under shared
// random stimulus, checked against a queue-level model via a scoreboard.
module tb_cic_interpolator;
    localparam int W = 5;
    localparam int SB = 4096;

    logic         clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_ce = 1'b0;
    logic         i_valid = 1'b0;
    logic [W-1:0] i_data = '0;
    logic         rdy [2];
    logic         ov [2];
    logic         ouf [2];
    logic [W-1:0] od [2];

    int checks = 0;
    int errors = 0;

    // reference model state per instance
    logic [W-1:0] mf [2][2];
    int           mn [2];
    int           ph [2];
    logic         run [2];
    logic [W-1:0] hq [2];
    logic [W:0]   eq [2][SB];
    int           eh [2];
    int           et [2];

    always #5 clk = ~clk;

    cic_interpolator #(.W(W), .R(5), .RW(32), .HOLD(0)) dut0 (
        .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_data(i_data), .i_valid(i_valid),
        .o_ready(rdy[0]), .o_data(od[0]), .o_valid(ov[0]), .o_underflow(ouf[0])
    );

    cic_interpolator #(.W(W), .R(4), .RW(32), .HOLD(1)) dut1 (
        .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_data(i_data), .i_valid(i_valid),
        .o_ready(rdy[1]), .o_data(od[1]), .o_valid(ov[1]), .o_underflow(ouf[1])
    );

    task automatic chk(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0d want %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            mn[k] = 0;
            ph[k] = 0;
            run[k] = 1'b0;
            hq[k] = '0;
        end
    endtask

    // One clock: drive inputs at the falling edge and predict the next rising edge
    task automatic step(input logic ce, input logic v);
        logic [W-1:0] d, out;
        logic         uf;
        int           n0, rr;
        @(negedge clk);
        d = W'($urandom);
        i_ce = ce;
        i_valid = v;
        i_data = d;
        for (int k = 0; k < 2; k++) begin
            rr = (k == 0) ? 5 : 4;
            n0 = mn[k];
            chk("ready", k, int'(rdy[k]), (n0 < 2) ? 1 : 0);
            if (run[k] && ce) begin
                uf = 1'b0;
                if (ph[k] == 0) begin
                    if (mn[k] > 0) begin
                        out = mf[k][0];
                        mf[k][0] = mf[k][1];
                        mn[k]--;
                    end else begin
                        out = '0;
                        uf = 1'b1;
                    end
                    hq[k] = out;
                end else begin
                    out = (k == 1) ? hq[k] : '0;
                end
                eq[k][et[k] % SB] = {uf, out};
                et[k]++;
                ph[k] = (ph[k] + 1) % rr;
            end
            if (v && n0 < 2) begin
                mf[k][mn[k]] = d;
                mn[k]++;
            end
            if (n0 >= 1) run[k] = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_ce = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_data", k, int'(od[k]), 0);
            chk("rst_valid", k, int'(ov[k]), 0);
            chk("rst_underflow", k, int'(ouf[k]), 0);
            chk("rst_ready", k, int'(rdy[k]), 1);
            chk("sb_pending_at_reset", k, et[k] - eh[k], 0);
        end
        model_clear();
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (!i_reset)
            for (int k = 0; k < 2; k++) begin
                if (ov[k]) begin
                    if (eh[k] == et[k]) chk("spurious_valid", k, int'(ov[k]), 0);
                    else begin
                        chk("data", k, int'(od[k]), int'(eq[k][eh[k] % SB][W-1:0]));
                        chk("underflow", k, int'(ouf[k]), int'(eq[k][eh[k] % SB][W]));
                        eh[k]++;
                    end
                end else chk("underflow_no_valid", k, int'(ouf[k]), 0);
            end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            eh[k] = 0;
            et[k] = 0;
        end
        model_clear();
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("init_data", k, int'(od[k]), 0);
            chk("init_valid", k, int'(ov[k]), 0);
        end
        i_reset = 1'b0;
        repeat (5) step(1'b1, 1'b0);
        for (int c = 0; c < 200; c++) step(1'b1, $urandom_range(3) == 0);
        for (int c = 0; c < 150; c++) step(c % 3 == 0, $urandom_range(7) == 0);
        repeat (10) step(1'b0, 1'b1);
        do_reset();
        repeat (5) step(1'b1, 1'b0);
        for (int c = 0; c < 300; c++) step($urandom_range(1) == 1, $urandom_range(9) < 3);
        repeat (20) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (12) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("sb_left", k, et[k] - eh[k], 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cic_interpolator.md
Name: cic_interpolator

Overview:
- Upsampling front-end for the CIC interpolation path, the transmit-side counterpart of the CIC decimation stage.
- Accepts low-rate signed samples through a valid/ready handshake into a 2-entry FIFO.
- Emits one output slot per high-rate clock enable: the sample in slot 0 of each R-slot frame, then zeros (zero-stuff) or repeats (hold) in slots 1..R-1.
- Feeds the CIC comb/integrator chain running at the high rate.

Parameters:
- W, 5, sample width (signed two's complement).
- R, 5, interpolation ratio; legal range 2 <= R < 2**RW.
- RW, 32, phase counter width.
- HOLD, 0, 0 = zero-stuff slots 1..R-1; 1 = repeat the current frame's sample.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset; asynchronous, active-high
- i_ce  in  1  high-rate clock enable; one output slot per asserted cycle
- i_data  in  W  signed input sample
- i_valid  in  1  i_data valid
- o_ready  out  1  FIFO can accept a sample (combinational from FIFO count)
- o_data  out  W  signed output sample, registered
- o_valid  out  1  one-cycle strobe, o_data updated this cycle
- o_underflow  out  1  one-cycle strobe, slot 0 with empty FIFO

Behaviour:
- Reset (async, any time, including mid-frame):
  - o_data = 0, o_valid = 0, o_underflow = 0.
  - FIFO count = 0; phase = 0; state = IDLE.
  - FIFO contents discarded. o_ready = 1 once reset deasserts.
- FIFO (2 entries):
  - Push when i_valid && o_ready. o_ready = (count < 2).
  - Pop occurs only in the phase-0 slot described below.
  - Simultaneous push and pop in one cycle is legal; count is unchanged and order is preserved.
  - Push while full is impossible because o_ready = 0.
- State IDLE:
  - i_ce ignored; o_valid = 0; phase held at 0.
  - Go to RUN on the first clock edge where count >= 1, including a count just reached by a push in that cycle's registered view. In other words, the transition is evaluated on registered count: the next cycle after the first sample is stored.
- State RUN, every cycle with i_ce = 1:
  - o_valid <= 1.
  - phase <= (phase == R-1) ? 0 : phase + 1.
  - If phase == 0 and count > 0: pop head; o_data <= head; latch head into the hold register.
  - If phase == 0 and count == 0: o_data <= 0; hold register <= 0; o_underflow <= 1; stay in RUN with phase advancing normally.
  - If phase != 0: o_data <= 0 when HOLD = 0, else o_data <= hold register.
- State RUN, cycles with i_ce = 0: o_valid <= 0, o_underflow <= 0, phase and o_data hold.
- o_underflow is 0 on every cycle except an underflow slot.
- RUN never returns to IDLE; only reset returns to IDLE.
- Latency: a sample popped in a phase-0 ce cycle appears on o_data one clock edge later, with o_valid = 1.
- Throughput: one input per R ce cycles sustained. Upstream has R-1 ce cycles to refill after each pop.
- Arithmetic: no gain or scaling; W bits are passed unmodified. Zero is all-zeros. Phase counter wraps at R-1, never at 2**RW.

Test Plan:
- Reset values: assert i_reset mid-frame with FIFO holding 2 samples -> o_data = 0, o_valid = 0, o_ready = 1 the same cycle. After release, no output until a new sample arrives.
- Zero-stuff, HOLD=0, R=5, i_ce = 1 always: push 3, 7, -4, each on time -> o_data stream 3,0,0,0,0,7,0,0,0,0,-4,0,0,0,0, each with o_valid = 1 and o_underflow = 0.
- Hold mode, HOLD=1, R=5: push 5, then -16 -> 5,5,5,5,5,-16,-16,-16,-16,-16; -16 (min value for W=5) passes unchanged.
- Backpressure: hold i_valid = 1 with 4 samples queued and no ce for 10 cycles -> o_ready drops to 0 after 2 pushes and FIFO order is preserved. Once ce resumes, o_ready returns high the cycle after the first pop.
- Underflow: push one sample 9, then none -> 9,0,0,0,0, then a slot-0 output of 0 with o_underflow = 1 for exactly one cycle. Pushing 2 afterwards -> 2 appears at the next phase-0 slot.
- Sparse ce: i_ce asserted every 3rd clock with R=4 -> o_valid pulses only on the cycle after each ce, phase advances only on ce, and the frame spans 12 clocks.
